// File: rtl/access_ctrl.sv
// access_ctrl: keypad access controller (code check, door/alarm timers, lockout).
// Ports: clk, reset (sync, high), key_valid, key[3:0], daytime -> door, alarm, locked, prog.
// Optional code reprogramming from OPEN via key A when ACCESS_CTRL_PROG_EN is defined.
module access_ctrl #(
    parameter int                    CODE_LEN     = 5,
    parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE = 20'h28B04,
    parameter int                    MAX_TRIES    = 3,
    parameter int                    TIMEOUT_CYC  = 1000,
    parameter int                    DOOR_CYC     = 500,
    parameter int                    ALARM_CYC    = 200,
    parameter int                    LOCK_CYC     = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key,
    input  logic       daytime,
    output logic       door,
    output logic       alarm,
    output logic       locked,
    output logic       prog
);

    localparam int M1   = (TIMEOUT_CYC > DOOR_CYC) ? TIMEOUT_CYC : DOOR_CYC;
    localparam int M2   = (ALARM_CYC > LOCK_CYC) ? ALARM_CYC : LOCK_CYC;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int TW   = $clog2(MAXC) + 1;
    localparam int IW   = $clog2(CODE_LEN) + 1;
    localparam int FW   = $clog2(MAX_TRIES) + 1;
    localparam int CW   = CODE_LEN * 4;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        OPEN,
        WRONG,
        LOCKOUT
`ifdef ACCESS_CTRL_PROG_EN
        , PROG
`endif
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [IW-1:0] idx, idx_n;
    logic          mis, mis_n, mis_any;
    logic [FW-1:0] fail, fail_n, fail_inc;
    logic [CW-1:0] code;
    logic [3:0]    nib;
    logic          is_digit, is_c, is_p, bad;

`ifdef ACCESS_CTRL_PROG_EN
    logic [CW-1:0] code_n, shadow, shadow_n;
`else
    assign code = DEFAULT_CODE;
`endif

    assign is_digit = key_valid && (key <= 4'd11);
    assign is_c     = key_valid && (key == 4'd12);
    assign is_p     = key_valid && (key == 4'd13);
    assign fail_inc = fail + 1'b1;

    // Nibble 0 is the most significant one.
    always_comb begin
        nib = '0;
        for (int i = 0; i < CODE_LEN; i++)
            if (idx == IW'(i))
                nib = code[(CODE_LEN-1-i)*4 +: 4];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            idx   <= '0;
            mis   <= 1'b0;
            fail  <= '0;
`ifdef ACCESS_CTRL_PROG_EN
            code   <= DEFAULT_CODE;
            shadow <= '0;
`endif
        end else begin
            state <= state_n;
            timer <= timer_n;
            idx   <= idx_n;
            mis   <= mis_n;
            fail  <= fail_n;
`ifdef ACCESS_CTRL_PROG_EN
            code   <= code_n;
            shadow <= shadow_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer + 1'b1;
        idx_n   = idx;
        mis_n   = mis;
        fail_n  = fail;
        mis_any = mis;
        bad     = 1'b0;
`ifdef ACCESS_CTRL_PROG_EN
        code_n   = code;
        shadow_n = shadow;
`endif
        unique case (state)
            IDLE, ENTRY: begin
                if (state == IDLE)
                    timer_n = '0;
                if (is_digit) begin
                    timer_n = '0;
                    mis_any = mis | (key != nib);
                    if (idx == IW'(CODE_LEN-1)) begin
                        idx_n = '0;
                        mis_n = 1'b0;
                        if (mis_any) begin
                            bad = 1'b1;
                        end else begin
                            state_n = OPEN;
                            fail_n  = '0;
                        end
                    end else begin
                        idx_n   = idx + 1'b1;
                        mis_n   = mis_any;
                        state_n = ENTRY;
                    end
                end else if (is_c) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    mis_n   = 1'b0;
                end else if (is_p) begin
                    idx_n = '0;
                    mis_n = 1'b0;
                    if (daytime) state_n = OPEN;
                    else         bad     = 1'b1;
                end else if (state == ENTRY &&
                             timer == TW'(TIMEOUT_CYC-1)) begin
                    bad = 1'b1;
                end
            end
            OPEN: begin
                if (timer == TW'(DOOR_CYC-1))
                    state_n = IDLE;
`ifdef ACCESS_CTRL_PROG_EN
                else if (key_valid && key == 4'd10) begin
                    state_n = PROG;
                    idx_n   = '0;
                end
`endif
            end
            WRONG: begin
                if (timer == TW'(ALARM_CYC-1))
                    state_n = IDLE;
            end
            LOCKOUT: begin
                if (timer == TW'(LOCK_CYC-1)) begin
                    state_n = IDLE;
                    fail_n  = '0;
                end
            end
`ifdef ACCESS_CTRL_PROG_EN
            PROG: begin
                if (is_digit) begin
                    timer_n  = '0;
                    shadow_n = (shadow << 4) | CW'(key);
                    if (idx == IW'(CODE_LEN-1)) begin
                        code_n  = shadow_n;
                        state_n = IDLE;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else if (is_c || is_p ||
                             timer == TW'(TIMEOUT_CYC-1)) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end
            end
`endif
            default: state_n = IDLE;
        endcase

        // Failed entry: bump the counter, lock out on the last allowed try.
        if (bad) begin
            fail_n  = fail_inc;
            state_n = (fail_inc == FW'(MAX_TRIES)) ? LOCKOUT : WRONG;
            idx_n   = '0;
            mis_n   = 1'b0;
        end
        if (state_n != state)
            timer_n = '0;
    end

    assign door   = (state == OPEN);
    assign alarm  = (state == WRONG) || (state == LOCKOUT);
    assign locked = (state == LOCKOUT);
`ifdef ACCESS_CTRL_PROG_EN
    assign prog = (state == PROG);
`else
    assign prog = 1'b0;
`endif

endmodule

// File: tb/tb_access_ctrl.sv
// tb_access_ctrl: directed self-checking bench for access_ctrl.
// Outputs are observed as {door, alarm, locked, prog} one time unit after each edge.
module tb_access_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key = 4'd0;
    logic       daytime = 1'b0;
    logic       door, alarm, locked, prog;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] OFF = 4'b0000;
    localparam logic [3:0] DR  = 4'b1000;
    localparam logic [3:0] AL  = 4'b0100;
    localparam logic [3:0] LK  = 4'b0110;
    localparam logic [3:0] PG  = 4'b0001;

    localparam logic [19:0] GOOD = 20'h28B04;
    localparam logic [19:0] BADC = 20'h28104;

    access_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key       (key),
        .daytime   (daytime),
        .door      (door),
        .alarm     (alarm),
        .locked    (locked),
        .prog      (prog)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key       = k;
        key_valid = 1'b1;
        step(1);
        key_valid = 1'b0;
    endtask

    task automatic enter(input logic [19:0] c);
        for (int i = 0; i < 5; i++)
            press(c[19-4*i -: 4]);
    endtask

    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] got;
        got = {door, alarm, locked, prog};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    initial begin
        step(3);
        chk("reset", OFF);
        reset = 1'b0;
        step(1);
        chk("idle", OFF);

        // Correct code: door for exactly 500 cycles.
        enter(GOOD);
        chk("open_first", DR);
        step(499);
        chk("open_last", DR);
        step(1);
        chk("open_done", OFF);

        // Wrong code: alarm for exactly 200 cycles (fail=1).
        enter(BADC);
        chk("wrong_first", AL);
        step(199);
        chk("wrong_last", AL);
        step(1);
        chk("wrong_done", OFF);

        // Correct code clears the counter.
        enter(GOOD);
        chk("open_clear", DR);
        step(500);

        // Two wrongs do not lock if the counter was cleared.
        enter(BADC);
        chk("wrong_a", AL);
        step(200);
        enter(BADC);
        chk("wrong_b_nolock", AL);
        step(200);
        enter(BADC);
        chk("lock_first", LK);
        enter(GOOD);
        chk("lock_ignores_code", LK);
        step(4994);
        chk("lock_last", LK);
        step(1);
        chk("lock_done", OFF);

        // Counter is zero after lockout: one wrong only alarms.
        enter(BADC);
        chk("after_lock_wrong", AL);
        step(200);
        enter(GOOD);
        chk("after_lock_open", DR);
        step(500);

        // Inactivity timeout during entry.
        press(4'd2);
        press(4'd8);
        step(999);
        chk("timeout_pending", OFF);
        step(1);
        chk("timeout_alarm", AL);
        step(200);

        // P override by daytime, and without daytime.
        daytime = 1'b1;
        press(4'd13);
        chk("p_day_open", DR);
        daytime = 1'b0;
        step(500);
        press(4'd13);
        chk("p_night_alarm", AL);
        step(200);
        enter(GOOD);
        chk("open_clear2", DR);
        step(500);

        // Key on the timeout edge wins and restarts the timer.
        press(4'd2);
        step(999);
        press(4'd8);
        chk("key_beats_timeout", OFF);
        press(4'hB);
        press(4'd0);
        press(4'd4);
        chk("key_beats_open", DR);
        step(500);

        // C keeps fail_cnt: two wrongs, clear, then wrong locks.
        enter(BADC);
        step(200);
        enter(BADC);
        step(200);
        press(4'd2);
        press(4'd8);
        press(4'd12);
        chk("clear_idle", OFF);
        enter(BADC);
        chk("clear_keeps_fail", LK);
        step(5000);
        chk("lock2_done", OFF);
        press(4'd2);
        press(4'd8);
        press(4'd12);
        enter(GOOD);
        chk("clear_then_open", DR);
        step(500);

        // Ignored keys do nothing.
        press(4'd14);
        press(4'd15);
        chk("ignored_keys", OFF);

        // Reset mid-entry drops partial digits.
        press(4'd2);
        press(4'd8);
        reset = 1'b1;
        step(1);
        chk("reset_mid_entry", OFF);
        reset = 1'b0;
        press(4'hB);
        press(4'd0);
        press(4'd4);
        chk("reset_lost_digits", OFF);
        press(4'd12);
        enter(GOOD);
        chk("open_before_reset", DR);
        reset = 1'b1;
        step(1);
        chk("reset_mid_open", OFF);
        reset = 1'b0;
        step(1);

`ifdef ACCESS_CTRL_PROG_EN
        enter(GOOD);
        press(4'd10);
        chk("prog_enter", PG);
        enter(20'h12345);
        chk("prog_done", OFF);
        enter(20'h12345);
        chk("new_code_open", DR);
        step(500);
        enter(GOOD);
        chk("old_code_alarm", AL);
        step(200);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        enter(GOOD);
        chk("reset_restores", DR);
        step(500);
`else
        enter(GOOD);
        press(4'd10);
        chk("a_ignored_in_open", DR);
        step(500);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/access_ctrl.md
# access_ctrl

Parametrised keypad access controller: the next generation of the digicode door lock. It accepts one key per cycle from the keypad decoder, checks a CODE_LEN-digit code held in a register, and drives the door strike and alarm for fixed durations. It adds an internal inactivity timeout, a failed-attempt counter with lockout, and optional code reprogramming. It sits between the keypad scanner and the door/alarm drivers.

## Interface
- CODE_LEN, 5, digits per code
- DEFAULT_CODE, 20'h28B04, reset code, CODE_LEN*4 bits; first key is compared against the most significant nibble
- MAX_TRIES, 3, consecutive failed entries that trigger lockout
- TIMEOUT_CYC, 1000, idle cycles allowed between keys during entry or programming
- DOOR_CYC, 500, cycles the door is held open
- ALARM_CYC, 200, cycles the alarm sounds after one failed entry
- LOCK_CYC, 5000, lockout duration in cycles
- clk  in  1  system clock, all logic on the rising edge
- reset  in  1  synchronous, active-high
- key_valid  in  1  key strobe, one key per asserted cycle
- key  in  4  key code: 0-9 digits, 10 = A, 11 = B, 12 = C (clear), 13 = P (pass); 14 and 15 are ignored
- daytime  in  1  enables P override
- door  out  1  door strike
- alarm  out  1  alarm
- locked  out  1  lockout active
- prog  out  1  programming mode active

## Operation
- Moore FSM with states IDLE, ENTRY, OPEN, WRONG, LOCKOUT, and PROG. Outputs are decoded from registered state.
- Reset: state IDLE, code = DEFAULT_CODE, fail_cnt = 0, digit index = 0, all timers 0, all outputs 0.
- Code digits are keys 0-11. There is no early exit: every digit is compared and a sticky mismatch flag accumulates the result.
- IDLE:
  - A digit compares against nibble 0, sets index = 1 and moves to ENTRY.
  - C is a no-op.
  - P with daytime=1 moves to OPEN.
  - P with daytime=0 is a failed entry.
- ENTRY:
  - A digit compares against nibble[index] and increments the index.
  - After the CODE_LEN-th digit: a match moves to OPEN and clears fail_cnt; a mismatch is a failed entry.
  - C returns to IDLE, clears index and mismatch, and leaves fail_cnt unchanged.
  - P behaves as in IDLE.
  - TIMEOUT_CYC cycles without key_valid is a failed entry. The timer restarts on every accepted key.
- Failed entry: fail_cnt increments. If the new value equals MAX_TRIES, go to LOCKOUT; otherwise go to WRONG. Index and mismatch are cleared.
- OPEN: door=1 for DOOR_CYC cycles, then IDLE. Keys other than A (see Configuration) are ignored.
- WRONG: alarm=1 for ALARM_CYC cycles, then IDLE. All keys are ignored, including C.
- LOCKOUT: alarm=1 and locked=1 for LOCK_CYC cycles. All keys are ignored. On exit, go to IDLE with fail_cnt = 0.
- Timer and counter widths are $clog2 of the largest count plus 1. No wrap is possible because every terminal count forces a state exit.

## Timing
- A key is sampled at the rising edge where key_valid=1. The decision on the final digit takes effect at the same edge, so door or alarm is visible the following cycle.
- door, alarm and locked stay high for exactly DOOR_CYC, ALARM_CYC or LOCK_CYC cycles respectively.
- Timeout and key on the same edge: the key wins and the timer restarts.
- reset mid-operation returns to the reset state at the next edge and restores DEFAULT_CODE.

## Configuration
- ACCESS_CTRL_PROG_EN defined:
  - In OPEN, key A moves to PROG. prog=1 and door=0 while in PROG.
  - The next CODE_LEN digit keys shift into a shadow register. On the last one, the code register is loaded and the FSM returns to IDLE.
  - C, P, or a TIMEOUT_CYC timeout aborts to IDLE with the old code kept.
- ACCESS_CTRL_PROG_EN undefined: no PROG state, A in OPEN is ignored, the code is constant DEFAULT_CODE, and prog is tied to 0.

## Test plan
- Reset, then keys 2,8,B,0,4 → door=1 the cycle after the last key, for 500 cycles, then IDLE.
- Keys 2,8,1,0,4 → alarm=1 for 200 cycles, fail_cnt=1; a correct code afterwards opens the door and clears fail_cnt.
- Three wrong codes in a row → locked=1 and alarm=1 for 5000 cycles; a correct code during lockout is ignored.
- Keys 2,8 then 1000 idle cycles → alarm; P with daytime=1 opens; P with daytime=0 raises the alarm.
- Keys 2,8,C,2,8,B,0,4 → door opens with fail_cnt unchanged; reset asserted mid-entry → IDLE with all outputs 0.
- With ACCESS_CTRL_PROG_EN defined: open, then A,1,2,3,4,5 → new code 12345 opens the door and 28B04 alarms; reset restores 28B04.
